// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multicycle RV32I core: ALU ops, FSM states,
// opcode/funct constants and the funct3/funct7 -> ALU op decode helper.
package cpu_pkg;

  typedef enum logic [3:0] {
    ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT
  } cpu_state_t;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct7[5] selects SUB only for register-register ops; ADDI never subtracts.
  function automatic alu_op_t decode_alu_op(input logic [6:0] opcode,
                                            input logic [2:0] funct3,
                                            input logic       alt);
    alu_op_t op;
    case (funct3)
      F3_ADD:  op = (opcode == OP && alt) ? SUB : ADD;
      F3_SLL:  op = SLL;
      F3_SLT:  op = SLT;
      F3_SLTU: op = SLTU;
      F3_XOR:  op = XOR;
      F3_SR:   op = alt ? SRA : SRL;
      F3_OR:   op = OR;
      default: op = AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU; shift amount is the low five bits of operand b.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_t         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  always_comb begin
    y = '0;
    case (op)
      ADD:     y = a + b;
      SUB:     y = a - b;
      AND:     y = a & b;
      OR:      y = a | b;
      XOR:     y = a ^ b;
      SLL:     y = a << shamt;
      SRL:     y = a >> shamt;
      SRA:     y = $signed(a) >>> shamt;
      SLT:     y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:    y = {{(XLEN-1){1'b0}}, (a < b)};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle RV32I integer core (FETCH/DECODE/EXECUTE/WRITEBACK) with loadable imem.
// Define CPU_BRANCH_EN to add BEQ/BNE/BLT/BGE/BLTU/BGEU; otherwise branches halt the core.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              NUM_REGS   = 32,
  parameter int              IMEM_DEPTH = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic                          run,
  output logic                          busy,
  output logic                          halted,
  output logic                          retire_valid,
  output logic [XLEN-1:0]               retire_pc,
  output logic [4:0]                    retire_rd,
  output logic [XLEN-1:0]               retire_data,
  output logic [XLEN-1:0]               pc_out,
  input  logic [4:0]                    dbg_raddr,
  output logic [XLEN-1:0]               dbg_rdata
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int RAW = $clog2(NUM_REGS);

  cpu_state_t      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, a_reg, b_reg, imm_reg, alu_out_reg;
  logic [31:0]     ir_reg;
  logic [XLEN-1:0] regs_reg [NUM_REGS];
  logic [31:0]     imem [IMEM_DEPTH];

  logic            retire_valid_reg;
  logic [XLEN-1:0] retire_pc_reg, retire_data_reg;
  logic [4:0]      retire_rd_reg;

  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [RAW-1:0]  rd_idx, rs1_idx, rs2_idx;
  logic [XLEN-1:0] imm_i, alu_b, alu_y, pc_seq, pc_wb;
  alu_op_t         alu_op;
  logic            illegal, writes_rd, rf_we;

  assign opcode  = ir_reg[6:0];
  assign funct3  = ir_reg[14:12];
  assign funct7  = ir_reg[31:25];
  assign rd_idx  = ir_reg[7 +: RAW];
  assign rs1_idx = ir_reg[15 +: RAW];
  assign rs2_idx = ir_reg[20 +: RAW];
  assign imm_i   = {{(XLEN-12){ir_reg[31]}}, ir_reg[31:20]};
  assign alu_op  = decode_alu_op(opcode, funct3, funct7[5]);
  assign alu_b   = (opcode == OP) ? b_reg : imm_reg;

  // Only OP/OP_IMM write rd; rd==x0 is treated as "no destination".
  assign writes_rd = (opcode == OP || opcode == OP_IMM) && (rd_idx != '0);
  assign rf_we     = (state_reg == WRITEBACK) && writes_rd;
  assign pc_seq    = pc_reg + XLEN'(4);

  // Anything not explicitly decoded (including ECALL/EBREAK and zero words) halts.
  always_comb begin
    illegal = 1'b1;
    case (opcode)
      OP:      illegal = !((funct7 == F7_BASE) ||
                           (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)));
      OP_IMM: begin
        case (funct3)
          F3_SLL:  illegal = (funct7 != F7_BASE);
          F3_SR:   illegal = !(funct7 == F7_BASE || funct7 == F7_ALT);
          default: illegal = 1'b0;
        endcase
      end
`ifdef CPU_BRANCH_EN
      BRANCH:  illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
`endif
      default: illegal = 1'b1;
    endcase
  end

  cpu_alu #(.XLEN(XLEN)) u_alu (
    .op (alu_op),
    .a  (a_reg),
    .b  (alu_b),
    .y  (alu_y)
  );

`ifdef CPU_BRANCH_EN
  logic [XLEN-1:0] imm_b, target_reg;
  logic            branch_cond, taken_reg;

  assign imm_b = {{(XLEN-13){ir_reg[31]}}, ir_reg[31], ir_reg[7],
                  ir_reg[30:25], ir_reg[11:8], 1'b0};

  always_comb begin
    case (funct3)
      F3_BEQ:  branch_cond = (a_reg == b_reg);
      F3_BNE:  branch_cond = (a_reg != b_reg);
      F3_BLT:  branch_cond = ($signed(a_reg) < $signed(b_reg));
      F3_BGE:  branch_cond = ($signed(a_reg) >= $signed(b_reg));
      F3_BLTU: branch_cond = (a_reg < b_reg);
      F3_BGEU: branch_cond = (a_reg >= b_reg);
      default: branch_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      taken_reg  <= 1'b0;
      target_reg <= '0;
    end else if (state_reg == EXECUTE) begin
      taken_reg  <= (opcode == BRANCH) && branch_cond;
      target_reg <= pc_reg + imm_b;
    end
  end

  assign pc_wb = taken_reg ? target_reg : pc_seq;
`else
  assign pc_wb = pc_seq;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (run) state_next = FETCH;
      FETCH:     state_next = DECODE;
      DECODE:    state_next = illegal ? HALT : EXECUTE;
      EXECUTE:   state_next = WRITEBACK;
      WRITEBACK: state_next = FETCH;
      HALT:      state_next = HALT;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg != IDLE) && (state_reg != HALT);
    halted = (state_reg == HALT);
  end

  // imem survives reset; writes land only while the core is idle.
  always_ff @(posedge clk) begin
    if (imem_we && state_reg == IDLE) imem[imem_waddr] <= imem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else if (rf_we) begin
      regs_reg[rd_idx] <= alu_out_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_reg           <= RESET_PC;
      ir_reg           <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      imm_reg          <= '0;
      alu_out_reg      <= '0;
      retire_valid_reg <= 1'b0;
      retire_pc_reg    <= '0;
      retire_rd_reg    <= '0;
      retire_data_reg  <= '0;
    end else begin
      retire_valid_reg <= 1'b0;
      case (state_reg)
        FETCH:   ir_reg <= imem[pc_reg[IAW+1:2]];
        DECODE: begin
          a_reg   <= regs_reg[rs1_idx];
          b_reg   <= regs_reg[rs2_idx];
          imm_reg <= imm_i;
        end
        EXECUTE: alu_out_reg <= alu_y;
        WRITEBACK: begin
          pc_reg           <= pc_wb;
          retire_valid_reg <= 1'b1;
          retire_pc_reg    <= pc_reg;
          retire_rd_reg    <= writes_rd ? 5'(rd_idx) : 5'd0;
          retire_data_reg  <= writes_rd ? alu_out_reg : '0;
        end
        default: ;
      endcase
    end
  end

  assign retire_valid = retire_valid_reg;
  assign retire_pc    = retire_pc_reg;
  assign retire_rd    = retire_rd_reg;
  assign retire_data  = retire_data_reg;
  assign pc_out       = pc_reg;
  assign dbg_rdata    = (dbg_raddr[RAW-1:0] == '0) ? '0 : regs_reg[dbg_raddr[RAW-1:0]];

endmodule

// File: tb/tb_multicycle_cpu.sv
// Directed self-checking bench for multicycle_cpu; branch expectations follow CPU_BRANCH_EN.
module tb_multicycle_cpu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_we = 1'b0;
  logic [4:0]  imem_waddr = '0;
  logic [31:0] imem_wdata = '0;
  logic        run = 1'b0;
  logic        busy, halted, retire_valid;
  logic [31:0] retire_pc, retire_data, pc_out, dbg_rdata;
  logic [4:0]  retire_rd;
  logic [4:0]  dbg_raddr = '0;

  int pass_cnt = 0;
  int total_cnt = 0;

  int          n_ret;
  bit          timed_out;
  logic [31:0] ret_pc   [32];
  logic [31:0] ret_data [32];
  logic [4:0]  ret_rd   [32];
  int          ret_cyc  [32];

  localparam logic [31:0] ECALL = 32'h00000073;
  localparam logic [31:0] ADDI_X7_99 = 32'h06300393;

  always #5 clk = ~clk;

  multicycle_cpu dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .run          (run),
    .busy         (busy),
    .halted       (halted),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .pc_out       (pc_out),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata)
  );

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; run = 1'b0; imem_we = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    @(negedge clk);
    imem_we = 1'b1; imem_waddr = 5'(addr); imem_wdata = w;
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic load_prog1();
    load_word(0, 32'h00500293);
    load_word(1, 32'h00700313);
    load_word(2, 32'h005303b3);
    load_word(3, ECALL);
  endtask

  task automatic rd_reg(input int idx, output logic [31:0] v);
    dbg_raddr = 5'(idx);
    #1;
    v = dbg_rdata;
  endtask

  // mode 1: imem write to word 0 together with run; mode 2: write to word 2 one cycle later.
  task automatic run_collect(input int max_cyc, input int mode, input logic [31:0] wword);
    @(negedge clk);
    run = 1'b1; n_ret = 0; timed_out = 1'b0;
    if (mode == 1) begin imem_we = 1'b1; imem_waddr = 5'd0; imem_wdata = wword; end
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (c == 1) begin
        run = 1'b0; imem_we = 1'b0;
        if (mode == 2) begin imem_we = 1'b1; imem_waddr = 5'd2; imem_wdata = wword; end
      end
      if (c == 2) imem_we = 1'b0;
      if (retire_valid && n_ret < 32) begin
        ret_pc[n_ret] = retire_pc; ret_rd[n_ret] = retire_rd;
        ret_data[n_ret] = retire_data; ret_cyc[n_ret] = c;
        $display("retire pc=%h rd=%0d data=%h cycle=%0d", retire_pc, retire_rd, retire_data, c);
        n_ret++;
      end
      if (halted) break;
      if (c == max_cyc) timed_out = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    do_reset();
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b expected 0", halted); else pass_cnt++;
    total_cnt++; if (retire_valid !== 1'b0) $display("FAIL reset_retire_valid: got %b expected 0", retire_valid); else pass_cnt++;
    total_cnt++; if (pc_out !== 32'h0) $display("FAIL reset_pc: got %h expected 0", pc_out); else pass_cnt++;
    total_cnt++; if ({retire_pc, retire_rd, retire_data} !== '0) $display("FAIL reset_retire_fields: got %h expected 0", {retire_pc, retire_rd, retire_data}); else pass_cnt++;
    rd_reg(5, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL reset_x5: got %h expected 0", v); else pass_cnt++;
  endtask

  task automatic test_add_program();
    logic [31:0] v;
    logic [4:0]  exp_rd [3] = '{5'd5, 5'd6, 5'd7};
    logic [31:0] exp_d  [3] = '{32'd5, 32'd7, 32'd12};
    do_reset();
    load_prog1();
    run_collect(100, 0, '0);
    total_cnt++; if (timed_out) $display("FAIL add_timeout: got no halt expected halt"); else pass_cnt++;
    total_cnt++; if (n_ret != 3) $display("FAIL add_retire_count: got %0d expected 3", n_ret); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (ret_pc[i] !== 32'(4 * i)) $display("FAIL add_pc%0d: got %h expected %h", i, ret_pc[i], 4 * i); else pass_cnt++;
      total_cnt++; if (ret_rd[i] !== exp_rd[i]) $display("FAIL add_rd%0d: got %0d expected %0d", i, ret_rd[i], exp_rd[i]); else pass_cnt++;
      total_cnt++; if (ret_data[i] !== exp_d[i]) $display("FAIL add_data%0d: got %h expected %h", i, ret_data[i], exp_d[i]); else pass_cnt++;
      total_cnt++; if (ret_cyc[i] != 5 + 4 * i) $display("FAIL add_latency%0d: got %0d expected %0d", i, ret_cyc[i], 5 + 4 * i); else pass_cnt++;
    end
    total_cnt++; if (halted !== 1'b1 || busy !== 1'b0) $display("FAIL add_halt_flags: got halted=%b busy=%b expected 1/0", halted, busy); else pass_cnt++;
    total_cnt++; if (pc_out !== 32'd12) $display("FAIL add_final_pc: got %h expected 0000000c", pc_out); else pass_cnt++;
    rd_reg(7, v);
    total_cnt++; if (v !== 32'd12) $display("FAIL add_x7: got %h expected 0000000c", v); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (retire_valid !== 1'b0 || pc_out !== 32'd12) $display("FAIL add_halt_stable: got rv=%b pc=%h expected 0/0000000c", retire_valid, pc_out); else pass_cnt++;
  endtask

  task automatic test_signed_shift();
    logic [31:0] v;
    logic [31:0] prog  [6] = '{32'hFFF00093, 32'h4040D113, 32'h01C0D193, 32'h00103233, 32'h0000A2B3, ECALL};
    logic [31:0] exp_v [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000000F, 32'h1, 32'h1};
    do_reset();
    for (int i = 0; i < 6; i++) load_word(i, prog[i]);
    run_collect(100, 0, '0);
    total_cnt++; if (timed_out || n_ret != 5) $display("FAIL shift_retires: got %0d (timeout=%b) expected 5", n_ret, timed_out); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      rd_reg(i + 1, v);
      total_cnt++; if (v !== exp_v[i]) $display("FAIL shift_x%0d: got %h expected %h", i + 1, v, exp_v[i]); else pass_cnt++;
    end
  endtask

  task automatic test_alu_mix();
    logic [31:0] prog [15] = '{32'h05500093, 32'h00F00113, 32'h402081B3, 32'h0020C233, 32'h0020E2B3,
                               32'h0020F333, 32'h002093B3, 32'h0023D433, 32'h0F00F493, 32'hFFF0C513,
                               32'hFFF0A593, 32'hFFF0B613, 32'h70006693, 32'h00411713, ECALL};
    logic [31:0] exp_d [14] = '{32'h55, 32'h0F, 32'h46, 32'h5A, 32'h5F, 32'h05, 32'h002A8000,
                                32'h55, 32'h50, 32'hFFFFFFAA, 32'h0, 32'h1, 32'h700, 32'hF0};
    do_reset();
    for (int i = 0; i < 15; i++) load_word(i, prog[i]);
    run_collect(200, 0, '0);
    total_cnt++; if (timed_out || n_ret != 14) $display("FAIL alu_retires: got %0d (timeout=%b) expected 14", n_ret, timed_out); else pass_cnt++;
    for (int i = 0; i < 14; i++) begin
      total_cnt++;
      if (ret_data[i] !== exp_d[i] || ret_rd[i] !== 5'(i + 1))
        $display("FAIL alu_op%0d: got rd=%0d data=%h expected rd=%0d data=%h", i, ret_rd[i], ret_data[i], i + 1, exp_d[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_x0_write();
    logic [31:0] v;
    do_reset();
    load_word(0, 32'h00900013);
    load_word(1, ECALL);
    run_collect(100, 0, '0);
    total_cnt++; if (timed_out || n_ret != 1) $display("FAIL x0_retires: got %0d expected 1", n_ret); else pass_cnt++;
    total_cnt++; if (ret_rd[0] !== 5'd0 || ret_pc[0] !== 32'h0) $display("FAIL x0_retire_rd: got rd=%0d pc=%h expected 0/0", ret_rd[0], ret_pc[0]); else pass_cnt++;
    rd_reg(0, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL x0_read: got %h expected 0", v); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_reset();
    load_prog1();
    @(negedge clk);
    run = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) run = 1'b0;
    end
    total_cnt++; if (busy !== 1'b1 || pc_out !== 32'd4) $display("FAIL mid_pre_state: got busy=%b pc=%h expected 1/00000004", busy, pc_out); else pass_cnt++;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    total_cnt++; if (busy !== 1'b0 || halted !== 1'b0) $display("FAIL mid_flags: got busy=%b halted=%b expected 0/0", busy, halted); else pass_cnt++;
    total_cnt++; if (pc_out !== 32'h0) $display("FAIL mid_pc: got %h expected 0", pc_out); else pass_cnt++;
    total_cnt++; if ({retire_valid, retire_pc, retire_rd, retire_data} !== '0) $display("FAIL mid_retire_fields: got %h expected 0", {retire_pc, retire_rd, retire_data}); else pass_cnt++;
    rd_reg(5, v);
    total_cnt++; if (v !== 32'h0) $display("FAIL mid_x5: got %h expected 0", v); else pass_cnt++;
    run_collect(100, 0, '0);
    total_cnt++; if (timed_out || n_ret != 3 || ret_data[2] !== 32'd12) $display("FAIL mid_rerun: got n=%0d data=%h expected 3/0000000c", n_ret, ret_data[2]); else pass_cnt++;
  endtask

  task automatic test_imem_guard();
    logic [31:0] v;
    do_reset();
    load_prog1();
    run_collect(100, 2, ADDI_X7_99);
    rd_reg(7, v);
    total_cnt++; if (n_ret != 3 || v !== 32'd12) $display("FAIL busy_write: got n=%0d x7=%h expected 3/0000000c", n_ret, v); else pass_cnt++;
    load_word(2, ADDI_X7_99);
    do_reset();
    run_collect(100, 0, '0);
    rd_reg(7, v);
    total_cnt++; if (n_ret != 3 || v !== 32'd12) $display("FAIL halt_write: got n=%0d x7=%h expected 3/0000000c", n_ret, v); else pass_cnt++;
  endtask

  task automatic test_we_and_run();
    logic [31:0] v;
    do_reset();
    load_word(0, ECALL);
    load_word(1, ECALL);
    run_collect(100, 1, 32'h00500293);
    rd_reg(5, v);
    total_cnt++; if (n_ret != 1 || v !== 32'd5 || ret_rd[0] !== 5'd5) $display("FAIL we_run: got n=%0d x5=%h expected 1/00000005", n_ret, v); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [31:0] v;
    do_reset();
    load_word(0, 32'h00500093);
    load_word(1, 32'h40109113);
    load_word(2, 32'h00100193);
    run_collect(100, 0, '0);
    rd_reg(2, v);
    total_cnt++; if (n_ret != 1 || halted !== 1'b1 || pc_out !== 32'd4 || v !== 32'h0) $display("FAIL bad_slli: got n=%0d halted=%b pc=%h x2=%h expected 1/1/00000004/0", n_ret, halted, pc_out, v); else pass_cnt++;
    do_reset();
    load_word(0, 32'h00000000);
    run_collect(100, 0, '0);
    total_cnt++; if (timed_out || n_ret != 0 || pc_out !== 32'h0) $display("FAIL zero_word: got n=%0d pc=%h expected 0/0", n_ret, pc_out); else pass_cnt++;
  endtask

  task automatic test_branch();
    logic [31:0] v;
    do_reset();
    load_word(0, 32'h00300093);
    load_word(1, 32'hFFF08093);
    load_word(2, 32'hFE009EE3);
    load_word(3, ECALL);
    run_collect(200, 0, '0);
    rd_reg(1, v);
`ifdef CPU_BRANCH_EN
    total_cnt++; if (timed_out || n_ret != 7) $display("FAIL branch_retires: got %0d expected 7", n_ret); else pass_cnt++;
    total_cnt++; if (v !== 32'h0 || pc_out !== 32'd12) $display("FAIL branch_final: got x1=%h pc=%h expected 0/0000000c", v, pc_out); else pass_cnt++;
`else
    total_cnt++; if (timed_out || n_ret != 2) $display("FAIL branch_retires: got %0d expected 2", n_ret); else pass_cnt++;
    total_cnt++; if (v !== 32'd2 || pc_out !== 32'd8 || halted !== 1'b1) $display("FAIL branch_halt: got x1=%h pc=%h halted=%b expected 2/00000008/1", v, pc_out, halted); else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_add_program();
    test_signed_shift();
    test_alu_mix();
    test_x0_write();
    test_reset_mid();
    test_imem_guard();
    test_we_and_run();
    test_illegal();
    test_branch();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
